// File: rtl/pipe_pkg.sv
// Shared types and constants for the F/D/X/M/W pipeline sequencing logic.
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALTED   = 3'd4
  } pipe_state_e;

  localparam logic [31:0] NOP_INSN         = 32'h0;
  localparam int          DRAIN_CYCLES_DEF = 3;
  localparam logic [4:0]  REG_ZERO         = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       rwe;
    logic [4:0] dst;
  } sb_entry_t;

  // A used, non-zero source collides with a live writer in the given stage.
  function automatic logic src_hits(input logic [4:0] src, input logic use_src,
                                    input sb_entry_t e);
    return use_src && (src != REG_ZERO) && e.valid && e.rwe && (e.dst == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry destination scoreboard for DX/XM/MW plus the RAW compare
// against the instruction currently in decode.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int WB_BYPASS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       adv_i,
  input  logic       in_valid_i,
  input  logic       in_rwe_i,
  input  logic [4:0] in_dst_i,
  input  logic       d_valid_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       use_rs_i,
  input  logic       use_rt_i,
  output logic       raw_o,
  output logic       valid_dx_o,
  output logic       valid_xm_o,
  output logic       valid_mw_o
);

  localparam bit CHECK_MW = (WB_BYPASS == 0);

  sb_entry_t dx_q, xm_q, mw_q;
  sb_entry_t in_e;

  // Bubbled entries are fully cleared so a stale dst can never match.
  always_comb begin
    in_e.valid = in_valid_i;
    in_e.rwe   = in_valid_i & in_rwe_i;
    in_e.dst   = in_valid_i ? in_dst_i : REG_ZERO;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's value from before the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dx_q <= '0;
      xm_q <= '0;
      mw_q <= '0;
    end else if (adv_i) begin
      dx_q <= in_e;
      xm_q <= dx_q;
      mw_q <= xm_q;
    end
  end

  logic hit_rs, hit_rt;

  always_comb begin
    hit_rs = src_hits(rs_i, use_rs_i, dx_q) | src_hits(rs_i, use_rs_i, xm_q)
           | (CHECK_MW & src_hits(rs_i, use_rs_i, mw_q));
    hit_rt = src_hits(rt_i, use_rt_i, dx_q) | src_hits(rt_i, use_rt_i, xm_q)
           | (CHECK_MW & src_hits(rt_i, use_rt_i, mw_q));
    raw_o  = d_valid_i & (hit_rs | hit_rt);
  end

  assign valid_dx_o = dx_q.valid;
  assign valid_xm_o = xm_q.valid;
  assign valid_mw_o = mw_q.valid;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: start/drain/halt FSM, stall and flush
// arbitration, RAW interlock and cycle/stall performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WB_BYPASS    = 1,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             halt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_rwe,
  input  logic [4:0]       id_dst,
  input  logic             ex_redirect,
  input  logic             i_busy,
  input  logic             d_busy,
  output logic             fetch_en,
  output logic             hold_fd,
  output logic             bubble_dx,
  output logic             flush_fd,
  output logic             freeze,
  output logic             valid_dx,
  output logic             valid_xm,
  output logic             valid_mw,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  pipe_state_e      state_q, state_d;
  logic             valid_fd_q, valid_fd_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, stall_q, stall_d;
  logic             raw_hit, redirect, count_en;

  hazard_scoreboard #(.WB_BYPASS(WB_BYPASS)) u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .adv_i      (!freeze),
    .in_valid_i (valid_fd_q & !bubble_dx),
    .in_rwe_i   (id_rwe),
    .in_dst_i   (id_dst),
    .d_valid_i  (valid_fd_q),
    .rs_i       (id_rs),
    .rt_i       (id_rt),
    .use_rs_i   (id_use_rs),
    .use_rt_i   (id_use_rt),
    .raw_o      (raw_hit),
    .valid_dx_o (valid_dx),
    .valid_xm_o (valid_xm),
    .valid_mw_o (valid_mw)
  );

  assign redirect = ex_redirect & valid_dx;

  // NOTE: every output and next-state variable gets a default before the
  // case so no path leaves one unassigned and a latch is never inferred.
  always_comb begin
    state_d    = state_q;
    valid_fd_d = valid_fd_q;
    drain_d    = drain_q;
    fetch_en   = 1'b0;
    hold_fd    = 1'b0;
    bubble_dx  = 1'b0;
    flush_fd   = 1'b0;
    freeze     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_fd_d = 1'b0;
        drain_d    = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (d_busy) begin
          freeze = 1'b1;
          if (state_q == ST_RUN && valid_xm) state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
          if (redirect) begin
            flush_fd   = 1'b1;
            bubble_dx  = 1'b1;
            fetch_en   = 1'b1;
            valid_fd_d = 1'b0;
          end else if (raw_hit || i_busy) begin
            hold_fd   = 1'b1;
            bubble_dx = 1'b1;
          end else if (valid_fd_q && halt) begin
            // The halt insn issues into DX; nothing behind it is fetched.
            state_d    = ST_DRAIN;
            drain_d    = '0;
            valid_fd_d = 1'b0;
          end else begin
            fetch_en   = 1'b1;
            valid_fd_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        bubble_dx  = 1'b1;
        valid_fd_d = 1'b0;
        if (drain_q == DRAIN_LAST) state_d = ST_HALTED;
        else                       drain_d = drain_q + DW'(1);
      end
      ST_HALTED: begin
        bubble_dx  = 1'b1;
        valid_fd_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign count_en = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT) || (state_q == ST_DRAIN);

  always_comb begin
    cycle_d = count_en ? cycle_q + CNT_W'(1) : cycle_q;
    stall_d = (count_en && (hold_fd || freeze)) ? stall_q + CNT_W'(1) : stall_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      valid_fd_q <= 1'b0;
      drain_q    <= '0;
      cycle_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_fd_q <= valid_fd_d;
      drain_q    <= drain_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
    end
  end

  assign state       = state_q;
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, halt, id_use_rs, id_use_rt, id_rwe, ex_redirect, i_busy, d_busy;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        fetch_en, hold_fd, bubble_dx, flush_fd, freeze;
  logic        valid_dx, valid_xm, valid_mw;
  logic [2:0]  state;
  logic [31:0] cycle_count, stall_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_cnt;
    logic [10:0] vec;
    logic [31:0] cyc;
    logic [31:0] stl;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];

  pipe_hazard_ctrl #(.WB_BYPASS(0), .DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .halt        (halt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rwe      (id_rwe),
    .id_dst      (id_dst),
    .ex_redirect (ex_redirect),
    .i_busy      (i_busy),
    .d_busy      (d_busy),
    .fetch_en    (fetch_en),
    .hold_fd     (hold_fd),
    .bubble_dx   (bubble_dx),
    .flush_fd    (flush_fd),
    .freeze      (freeze),
    .valid_dx    (valid_dx),
    .valid_xm    (valid_xm),
    .valid_mw    (valid_mw),
    .state       (state),
    .cycle_count (cycle_count),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  logic [10:0] obs_vec;
  assign obs_vec = {state, fetch_en, hold_fd, bubble_dx, flush_fd, freeze,
                    valid_dx, valid_xm, valid_mw};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // bits = {fetch_en, hold_fd, bubble_dx, flush_fd, freeze, valid_dx, valid_xm, valid_mw}
  task automatic expv(input string nm, input logic [2:0] st, input logic [7:0] bits);
    exp_t e;
    e.is_cnt = 1'b0;
    e.vec    = {st, bits};
    e.cyc    = '0;
    e.stl    = '0;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic expc(input string nm, input logic [31:0] cyc, input logic [31:0] stl);
    exp_t e;
    e.is_cnt = 1'b1;
    e.vec    = '0;
    e.cyc    = cyc;
    e.stl    = stl;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                          input logic urs, input logic urt, input logic rwe);
    id_rs     = rs;
    id_rt     = rt;
    id_dst    = dst;
    id_use_rs = urs;
    id_use_rt = urt;
    id_rwe    = rwe;
  endtask

  // Monitor: compares every queued expectation in the cycle it was issued.
  initial begin
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if (e.is_cnt) begin
          check({n, ".cycle_count"}, 64'(cycle_count), 64'(e.cyc));
          check({n, ".stall_count"}, 64'(stall_count), 64'(e.stl));
        end else begin
          check(n, 64'(obs_vec), 64'(e.vec));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    start = 0; halt = 0; ex_redirect = 0; i_busy = 0; d_busy = 0;
    drive_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc(); expv("por", 3'd0, 8'b0000_0000); expc("por", 0, 0);
    cyc(); reset_n = 1'b1; expv("idle", 3'd0, 8'b0000_0000);

    // RAW: add $3,$1,$2 then add $4,$3,$5 with no MW bypass
    cyc(); start = 1'b1; expv("start", 3'd0, 8'b0000_0000);
    cyc(); start = 1'b0; expv("run_first", 3'd1, 8'b1000_0000);
    cyc(); drive_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1); expv("raw_a", 3'd1, 8'b1000_0000);
    cyc(); drive_id(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1); expv("raw_dx", 3'd1, 8'b0110_0100);
    cyc(); expv("raw_xm", 3'd1, 8'b0110_0010);
    cyc(); expv("raw_mw", 3'd1, 8'b0110_0001);
    cyc(); expv("raw_clear", 3'd1, 8'b1000_0000);
    cyc(); drive_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    expv("b_in_dx", 3'd1, 8'b1000_0100); expc("raw_cnt", 6, 3);
    cyc(); expv("shift1", 3'd1, 8'b1000_0110);
    cyc(); expv("shift2", 3'd1, 8'b1000_0111); expc("pre_reset", 8, 3);

    // asynchronous reset mid-RUN
    cyc(); reset_n = 1'b0; expv("reset_mid", 3'd0, 8'b0000_0000); expc("reset_mid", 0, 0);
    cyc(); reset_n = 1'b1; expv("idle2", 3'd0, 8'b0000_0000);

    // register $0 never hazards
    cyc(); start = 1'b1; expv("start2", 3'd0, 8'b0000_0000);
    cyc(); start = 1'b0; expv("run2", 3'd1, 8'b1000_0000);
    cyc(); drive_id(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1); expv("r0_a", 3'd1, 8'b1000_0000);
    cyc(); drive_id(5'd0, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1); expv("r0_b", 3'd1, 8'b1000_0100);
    cyc(); drive_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    expv("r0_nop", 3'd1, 8'b1000_0110); expc("r0_cnt", 3, 0);

    // redirect overriding a pending RAW stall
    cyc(); drive_id(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1); expv("br_c", 3'd1, 8'b1000_0111);
    cyc(); drive_id(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1); ex_redirect = 1'b1;
    expv("redirect", 3'd1, 8'b1011_0111);
    cyc(); ex_redirect = 1'b0; expv("post_flush", 3'd1, 8'b1000_0011);
    cyc(); drive_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    expv("bubble2", 3'd1, 8'b1000_0001); expc("br_cnt", 7, 0);

    // instruction memory busy
    cyc(); i_busy = 1'b1; expv("ibusy", 3'd1, 8'b0110_0100);
    cyc(); i_busy = 1'b0; expv("ibusy_done", 3'd1, 8'b1000_0010);
    cyc(); expv("fill", 3'd1, 8'b1000_0101);

    // data memory busy for four cycles with XM valid
    cyc(); d_busy = 1'b1; expv("dbusy_run", 3'd1, 8'b0000_1110);
    for (int i = 0; i < 3; i++) begin
      cyc(); expv("mem_wait", 3'd2, 8'b0000_1110);
    end
    cyc(); d_busy = 1'b0; expv("mem_exit", 3'd2, 8'b1000_0110);
    cyc(); expv("resume", 3'd1, 8'b1000_0111); expc("mem_cnt", 16, 5);

    // halt, drain, sticky HALTED
    cyc(); halt = 1'b1; expv("halt", 3'd1, 8'b0000_0111);
    cyc(); halt = 1'b0; expv("drain1", 3'd3, 8'b0010_0111);
    cyc(); expv("drain2", 3'd3, 8'b0010_0011);
    cyc(); expv("drain3", 3'd3, 8'b0010_0001);
    cyc(); start = 1'b1; expv("halted", 3'd4, 8'b0010_0000);
    cyc(); start = 1'b0; expv("halted_start", 3'd4, 8'b0010_0000); expc("halt_cnt", 21, 5);
    cyc(); expv("halted_sticky", 3'd4, 8'b0010_0000);

    cyc();
    cyc();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
